// File: rtl/lsu_mem_stage.sv
// Load/store unit: one data-memory request per load/store, byte-lane steering, load extension, bus timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses are trapped without touching memory.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        misalign,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshake: dm_req rises on entry to ACCESS and holds with dm_* stable until
    // the first cycle dm_ready=1; that cycle completes the transfer.
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_funct3;
    logic [1:0]    r_alo;
    logic          r_req;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_wdata;
    logic [31:0]   r_load;
    logic          r_done;
    logic          r_err;

    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_ext;

    // Store lane layout from the incoming instruction, captured in IDLE.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (mem_we) begin
            case (mem_funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << alu_res[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {alu_res[1], 1'b0};
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    // Load extraction uses the captured low address bits against the live read data.
    always_comb begin
        case (r_alo)
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_alo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b101:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = dm_rdata;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    assign w_misalign = ((mem_funct3[1:0] == 2'b01) && alu_res[0]) ||
                        (mem_funct3[1] && (alu_res[1:0] != 2'b00));
    assign misalign   = r_misalign;
`else
    assign misalign   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_funct3 <= 3'b000;
            r_alo    <= 2'b00;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_wstrb  <= 4'b0000;
            r_wdata  <= 32'h0;
            r_load   <= 32'h0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (mem_en) begin
                        r_addr   <= {alu_res[31:2], 2'b00};
                        r_funct3 <= mem_funct3;
                        r_alo    <= alu_res[1:0];
                        r_wdata  <= w_wdata;
                        r_cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            // Trapped: never reaches memory, reported as a completed access.
                            r_wstrb    <= 4'b0000;
                            r_load     <= 32'h0;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_wstrb <= w_wstrb;
                            r_req   <= 1'b1;
                            r_we    <= mem_we;
                            r_state <= S_ACCESS;
                        end
`else
                        r_wstrb <= w_wstrb;
                        r_req   <= 1'b1;
                        r_we    <= mem_we;
                        r_state <= S_ACCESS;
`endif
                    end
                end
                S_ACCESS: begin
                    if (dm_ready) begin
                        // Ready wins over a timeout landing on the same cycle.
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_load <= w_load_ext;
                        end
                    end else if (r_cnt == LAST_CNT) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_load  <= 32'h0;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Busy drops in DONE/ERR so the pipeline advances on the completing edge.
    assign lsu_busy    = ((r_state == S_IDLE) && mem_en) || (r_state == S_ACCESS);
    assign lsu_done    = r_done;
    assign bus_err     = r_err;
    assign load_data   = r_load;
    assign dm_req      = r_req;
    assign dm_we       = r_we;
    assign dm_addr     = r_addr;
    assign dm_wstrb    = r_wstrb;
    assign dm_wdata    = r_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage: loads, stores, timeout, reset mid-access, misalignment.
// Builds for either setting of MISALIGN_TRAP_EN.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] load_data;
    logic        bus_err;
    logic        misalign;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations recorded by the driver for the test tasks to judge.
    int          obs_done_cyc;
    int          obs_req_cyc;
    logic        obs_busy0;
    logic        obs_busy_acc;
    logic        obs_busy_done;
    logic        obs_done_after;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_wstrb;
    logic [31:0] obs_wdata;
    logic [31:0] obs_ld;
    logic        obs_err;
    logic        obs_mis;

    logic [2:0]  ld_f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ld_addr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    logic [31:0] ld_rd   [5] = '{32'h80000000, 32'h80000000, 32'h80011234, 32'h00018765, 32'h00007F00};
    logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008765, 32'h0000007F};

    logic [2:0]  st_f3   [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] st_addr [4] = '{32'h202, 32'h202, 32'h20C, 32'h201};
    logic [31:0] st_sd   [4] = '{32'h000000A5, 32'h1234BEEF, 32'h12345678, 32'h000000C3};
    logic [31:0] st_eadr [4] = '{32'h200, 32'h200, 32'h20C, 32'h200};
    logic [3:0]  st_estb [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] st_ewd  [4] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678, 32'hC3C3C3C3};

    lsu_mem_stage #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_funct3  (mem_funct3),
        .alu_res     (alu_res),
        .store_data  (store_data),
        .lsu_busy    (lsu_busy),
        .lsu_done    (lsu_done),
        .load_data   (load_data),
        .bus_err     (bus_err),
        .misalign    (misalign),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wstrb    (dm_wstrb),
        .dm_wdata    (dm_wdata),
        .dm_ready    (dm_ready),
        .dm_rdata    (dm_rdata),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Called just after a clock edge with the DUT idle. Cycle 0 presents mem_en;
    // dm_ready is raised on ACCESS cycle ready_at (-1 = never). Returns one cycle after done.
    task automatic drive_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rdata, input int ready_at);
        int cyc;
        int acc;
        cyc = 0;
        acc = 0;
        obs_done_cyc = -1;
        obs_req_cyc = 0;
        obs_busy_acc = 1'b1;
        obs_busy_done = 1'b1;
        obs_done_after = 1'b1;
        obs_we = 1'b0;
        obs_addr = 32'h0;
        obs_wstrb = 4'h0;
        obs_wdata = 32'h0;
        obs_ld = 32'h0;
        obs_err = 1'b0;
        obs_mis = 1'b0;
        mem_en = 1'b1;
        mem_we = we;
        mem_funct3 = f3;
        alu_res = addr;
        store_data = sd;
        dm_ready = 1'b0;
        #1 obs_busy0 = lsu_busy;
        while (cyc < 40 && obs_done_cyc < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            mem_en = 1'b0;
            dm_ready = 1'b0;
            dm_rdata = 32'h0;
            if (lsu_done) begin
                obs_done_cyc = cyc;
                obs_err = bus_err;
                obs_mis = misalign;
                obs_ld = load_data;
                obs_busy_done = lsu_busy;
            end else if (dm_req) begin
                obs_req_cyc++;
                obs_we = dm_we;
                obs_addr = dm_addr;
                obs_wstrb = dm_wstrb;
                obs_wdata = dm_wdata;
                obs_busy_acc = obs_busy_acc & lsu_busy;
                if (acc == ready_at) begin
                    dm_ready = 1'b1;
                    dm_rdata = rdata;
                end
                acc++;
            end
        end
        @(posedge clk);
        #1;
        obs_done_after = lsu_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_en = 1'b0;
        mem_we = 1'b0;
        mem_funct3 = 3'b000;
        alu_res = 32'h0;
        store_data = 32'h0;
        dm_ready = 1'b0;
        dm_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req got %b exp 0", dm_req); end
        n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_dm_we got %b exp 0", dm_we); end
        n_cmp++; if (lsu_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", lsu_done); end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b exp 0", misalign); end
        n_cmp++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", dm_addr); end
        n_cmp++; if (dm_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_wstrb got %b exp 0000", dm_wstrb); end
        n_cmp++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", dm_wdata); end
        n_cmp++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load_data got %h exp 0", load_data); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", lsu_busy); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_lw();
        drive_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        n_cmp++; if (obs_busy0 !== 1'b1) begin n_fail++; $display("FAIL lw_busy_c0 got %b exp 1", obs_busy0); end
        n_cmp++; if (obs_req_cyc !== 1) begin n_fail++; $display("FAIL lw_req_cycles got %0d exp 1", obs_req_cyc); end
        n_cmp++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h exp 00000100", obs_addr); end
        n_cmp++; if (obs_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lw_wstrb got %b exp 0000", obs_wstrb); end
        n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL lw_we got %b exp 0", obs_we); end
        n_cmp++; if (obs_busy_acc !== 1'b1) begin n_fail++; $display("FAIL lw_busy_access got %b exp 1", obs_busy_acc); end
        n_cmp++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL lw_done_cycle got %0d exp 2", obs_done_cyc); end
        n_cmp++; if (obs_busy_done !== 1'b0) begin n_fail++; $display("FAIL lw_busy_done got %b exp 0", obs_busy_done); end
        n_cmp++; if (obs_ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", obs_ld); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL lw_bus_err got %b exp 0", obs_err); end
        n_cmp++; if (obs_done_after !== 1'b0) begin n_fail++; $display("FAIL lw_done_pulse got %b exp 0", obs_done_after); end
        n_cmp++; if (load_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data_held got %h exp deadbeef", load_data); end
    endtask

    task automatic test_load_ext();
        for (int i = 0; i < 5; i++) begin
            drive_access(1'b0, ld_f3[i], ld_addr[i], 32'h0, ld_rd[i], i % 3);
            n_cmp++; if (obs_ld !== ld_exp[i]) begin n_fail++; $display("FAIL load_ext[%0d] got %h exp %h", i, obs_ld, ld_exp[i]); end
            n_cmp++; if (obs_done_cyc !== (i % 3) + 2) begin n_fail++; $display("FAIL load_latency[%0d] got %0d exp %0d", i, obs_done_cyc, (i % 3) + 2); end
        end
    endtask

    task automatic test_store();
        drive_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h11223344, 1);
        for (int i = 0; i < 4; i++) begin
            drive_access(1'b1, st_f3[i], st_addr[i], st_sd[i], 32'hFFFFFFFF, i);
            n_cmp++; if (obs_addr !== st_eadr[i]) begin n_fail++; $display("FAIL st_addr[%0d] got %h exp %h", i, obs_addr, st_eadr[i]); end
            n_cmp++; if (obs_wstrb !== st_estb[i]) begin n_fail++; $display("FAIL st_wstrb[%0d] got %b exp %b", i, obs_wstrb, st_estb[i]); end
            n_cmp++; if (obs_wdata !== st_ewd[i]) begin n_fail++; $display("FAIL st_wdata[%0d] got %h exp %h", i, obs_wdata, st_ewd[i]); end
            n_cmp++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL st_we[%0d] got %b exp 1", i, obs_we); end
            n_cmp++; if (obs_ld !== 32'h11223344) begin n_fail++; $display("FAIL st_load_kept[%0d] got %h exp 11223344", i, obs_ld); end
            n_cmp++; if (obs_done_cyc !== i + 2) begin n_fail++; $display("FAIL st_latency[%0d] got %0d exp %0d", i, obs_done_cyc, i + 2); end
        end
    endtask

    task automatic test_timeout();
        drive_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1);
        n_cmp++; if (obs_req_cyc !== 16) begin n_fail++; $display("FAIL to_access_cycles got %0d exp 16", obs_req_cyc); end
        n_cmp++; if (obs_done_cyc !== 17) begin n_fail++; $display("FAIL to_done_cycle got %0d exp 17", obs_done_cyc); end
        n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err got %b exp 1", obs_err); end
        n_cmp++; if (obs_ld !== 32'h0) begin n_fail++; $display("FAIL to_load_data got %h exp 0", obs_ld); end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got %b exp 0", bus_err); end
        drive_access(1'b0, 3'b010, 32'h404, 32'h0, 32'h55AA55AA, 0);
        n_cmp++; if (obs_ld !== 32'h55AA55AA) begin n_fail++; $display("FAIL to_next_load got %h exp 55aa55aa", obs_ld); end
        n_cmp++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL to_next_latency got %0d exp 2", obs_done_cyc); end
    endtask

    task automatic test_ready_on_last();
        drive_access(1'b0, 3'b001, 32'h502, 32'h0, 32'h7ABC0000, 15);
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL last_bus_err got %b exp 0", obs_err); end
        n_cmp++; if (obs_done_cyc !== 17) begin n_fail++; $display("FAIL last_done_cycle got %0d exp 17", obs_done_cyc); end
        n_cmp++; if (obs_ld !== 32'h00007ABC) begin n_fail++; $display("FAIL last_load got %h exp 00007abc", obs_ld); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_funct3 = 3'b010;
        alu_res = 32'h3F4;
        store_data = 32'h87654321;
        dm_ready = 1'b0;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before got %b exp 1", dm_req); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req got %b exp 0", dm_req); end
        n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we got %b exp 0", dm_we); end
        n_cmp++; if (lsu_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b exp 0", lsu_done); end
        n_cmp++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_addr got %h exp 0", dm_addr); end
        n_cmp++; if (dm_wstrb !== 4'h0) begin n_fail++; $display("FAIL rmid_wstrb got %b exp 0000", dm_wstrb); end
        n_cmp++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL rmid_wdata got %h exp 0", dm_wdata); end
        n_cmp++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rmid_load_data got %h exp 0", load_data); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", lsu_busy); end
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | lsu_done | dm_req;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet got %b exp 0", seen); end
    endtask

    task automatic test_misalign();
        drive_access(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0);
`ifdef MISALIGN_TRAP_EN
        n_cmp++; if (obs_req_cyc !== 0) begin n_fail++; $display("FAIL mis_lw_req got %0d exp 0", obs_req_cyc); end
        n_cmp++; if (obs_done_cyc !== 1) begin n_fail++; $display("FAIL mis_lw_done_cycle got %0d exp 1", obs_done_cyc); end
        n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL mis_lw_flag got %b exp 1", obs_mis); end
        n_cmp++; if (obs_ld !== 32'h0) begin n_fail++; $display("FAIL mis_lw_load got %h exp 0", obs_ld); end
        n_cmp++; if (obs_busy0 !== 1'b1) begin n_fail++; $display("FAIL mis_lw_busy_c0 got %b exp 1", obs_busy0); end
        n_cmp++; if (obs_busy_done !== 1'b0) begin n_fail++; $display("FAIL mis_lw_busy_c1 got %b exp 0", obs_busy_done); end
        drive_access(1'b1, 3'b001, 32'h203, 32'h00007E11, 32'h0, 0);
        n_cmp++; if (obs_req_cyc !== 0) begin n_fail++; $display("FAIL mis_sh_req got %0d exp 0", obs_req_cyc); end
        n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL mis_sh_flag got %b exp 1", obs_mis); end
`else
        n_cmp++; if (obs_req_cyc !== 1) begin n_fail++; $display("FAIL mis_lw_req got %0d exp 1", obs_req_cyc); end
        n_cmp++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL mis_lw_addr got %h exp 00000100", obs_addr); end
        n_cmp++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL mis_lw_done_cycle got %0d exp 2", obs_done_cyc); end
        n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL mis_lw_flag got %b exp 0", obs_mis); end
        n_cmp++; if (obs_ld !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_lw_load got %h exp cafef00d", obs_ld); end
        drive_access(1'b1, 3'b001, 32'h203, 32'h00007E11, 32'h0, 0);
        n_cmp++; if (obs_wstrb !== 4'b1100) begin n_fail++; $display("FAIL mis_sh_wstrb got %b exp 1100", obs_wstrb); end
        n_cmp++; if (obs_wdata !== 32'h7E117E11) begin n_fail++; $display("FAIL mis_sh_wdata got %h exp 7e117e11", obs_wdata); end
        n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL mis_sh_flag got %b exp 0", obs_mis); end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_timeout();
        test_ready_on_last();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
